// File: rtl/phase_frame_packer_pkg.sv
// Shared types for phase_frame_packer: FSM state encoding and the
// error-cause codes reported on the debug port.
package phase_frame_packer_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

  typedef logic [1:0] err_cause_t;

  localparam err_cause_t ERR_NONE      = 2'd0;
  localparam err_cause_t ERR_DUPLICATE = 2'd1;
  localparam err_cause_t ERR_BAD_DEST  = 2'd2;
  localparam err_cause_t ERR_TIMEOUT   = 2'd3;

endpackage

// File: rtl/phase_frame_packer_if.sv
// AXI-stream style bus carrying data, dest, valid, ready and last.
// Handshake: a beat transfers on a rising clock edge where valid and ready
// are both high; the source keeps data/dest/last stable while valid && !ready.
interface phase_frame_packer_if #(
  parameter int DATA_W = 16,
  parameter int DEST_W = 8
);
  logic [DATA_W-1:0] data;
  logic [DEST_W-1:0] dest;
  logic              valid;
  logic              ready;
  logic              last;

  modport master (output data, dest, valid, last, input ready);
  modport slave  (input data, dest, valid, last, output ready);
endinterface

// File: rtl/phase_sample_bank.sv
// Per-phase register file with presence mask: write by dest, read by index,
// bulk clear, and a look-ahead flag telling whether the mask including the
// current write becomes complete.
module phase_sample_bank #(
  parameter int N_PHASES = 6,
  parameter int DATA_W   = 16,
  parameter int IDX_W    = $clog2(N_PHASES)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clear,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              present,
  output logic              mask_empty,
  output logic              all_present_next
);

  logic [DATA_W-1:0]   bank_q [N_PHASES];
  logic [DATA_W-1:0]   bank_d [N_PHASES];
  logic [N_PHASES-1:0] mask_q, mask_d;
  logic [N_PHASES-1:0] sel;
  logic [N_PHASES-1:0] hit;

  // Decode write index, read mux, and next bank/mask contents.
  always_comb begin
    sel     = '0;
    hit     = '0;
    rd_data = '0;
    for (int i = 0; i < N_PHASES; i++) begin
      sel[i] = (wr_idx == IDX_W'(i));
      hit[i] = wr_en && sel[i];
      if (rd_idx == IDX_W'(i)) rd_data = bank_q[i];
      bank_d[i] = hit[i] ? wr_data : bank_q[i];
    end
    present          = |(mask_q & sel);
    mask_empty       = ~|mask_q;
    // Independent of clear so the controller can decide clear from it.
    all_present_next = &(mask_q | hit);
    // A write in the clearing cycle survives as the first sample of a new frame.
    mask_d           = (clear ? '0 : mask_q) | hit;
  end

  // Sample storage and presence mask; reset discards any partial frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
      for (int i = 0; i < N_PHASES; i++) bank_q[i] <= '0;
    end else begin
      mask_q <= mask_d;
      for (int i = 0; i < N_PHASES; i++) bank_q[i] <= bank_d[i];
    end
  end

endmodule

// File: rtl/phase_frame_packer.sv
// Collects one sample per phase in any order, then emits the frame in
// ascending dest order with last on the final phase.
// Optional frame timeout: define PHASE_FRAME_PACKER_TIMEOUT_EN.
module phase_frame_packer
  import phase_frame_packer_pkg::*;
#(
  parameter int N_PHASES        = 6,
  parameter int DATA_PATH_WIDTH = 16,
  parameter int DEST_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic                 clock,
  input  logic                 reset,
  phase_frame_packer_if.slave  phases_in,
  phase_frame_packer_if.master frame_out,
  output logic                 frame_error,
  output logic [15:0]          frames_done,
  output state_t               dbg_state,
  output err_cause_t           dbg_err_cause
);

  localparam int IDX_W = $clog2(N_PHASES);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [15:0]          frames_done_q, frames_done_d;
  logic                 err_q, err_d;
  err_cause_t           cause_q, cause_d;
  logic                 in_hs, out_hs, dest_ok, wr_en, is_last, clear;
  logic [DATA_PATH_WIDTH-1:0] rd_data;
  logic                 present, mask_empty, all_present_next;
  logic                 timeout_hit;
  logic                 unused_in_last;

  assign unused_in_last = phases_in.last;

  assign in_hs   = phases_in.valid && phases_in.ready;
  assign out_hs  = frame_out.valid && frame_out.ready;
  assign dest_ok = phases_in.dest < DEST_WIDTH'(N_PHASES);
  assign wr_en   = in_hs && dest_ok;
  assign is_last = (idx_q == IDX_W'(N_PHASES - 1));

`ifdef PHASE_FRAME_PACKER_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;

  assign timeout_hit = !mask_empty && (cnt_q == 32'(TIMEOUT_CYCLES - 1));

  // Frame age: starts at the first accepted sample, counts only in COLLECT.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != COLLECT || all_present_next) cnt_d = '0;
    else if (mask_empty || timeout_hit)         cnt_d = wr_en ? 32'd1 : 32'd0;
    else                                        cnt_d = cnt_q + 32'd1;
  end

  // Frame age register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  phase_sample_bank #(
    .N_PHASES (N_PHASES),
    .DATA_W   (DATA_PATH_WIDTH),
    .IDX_W    (IDX_W)
  ) u_bank (
    .clock            (clock),
    .reset            (reset),
    .wr_en            (wr_en),
    .wr_idx           (phases_in.dest[IDX_W-1:0]),
    .wr_data          (phases_in.data),
    .clear            (clear),
    .rd_idx           (idx_q),
    .rd_data          (rd_data),
    .present          (present),
    .mask_empty       (mask_empty),
    .all_present_next (all_present_next)
  );

  // Next-state, emit index, frame counter and registered error cause.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    frames_done_d = frames_done_q;
    err_d         = 1'b0;
    cause_d       = cause_q;
    clear         = 1'b0;
    case (state_q)
      COLLECT: begin
        if (in_hs && !dest_ok) begin
          err_d   = 1'b1;
          cause_d = ERR_BAD_DEST;
        end else if (in_hs && present) begin
          err_d   = 1'b1;
          cause_d = ERR_DUPLICATE;
        end
        if (all_present_next) begin
          state_d = EMIT;
          idx_d   = '0;
        end else if (timeout_hit) begin
          clear   = 1'b1;
          err_d   = 1'b1;
          cause_d = ERR_TIMEOUT;
        end
      end
      EMIT: begin
        if (out_hs) begin
          if (is_last) begin
            state_d       = COLLECT;
            idx_d         = '0;
            clear         = 1'b1;
            frames_done_d = frames_done_q + 16'd1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Control registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= COLLECT;
      idx_q         <= '0;
      frames_done_q <= '0;
      err_q         <= 1'b0;
      cause_q       <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      frames_done_q <= frames_done_d;
      err_q         <= err_d;
      cause_q       <= cause_d;
    end
  end

  // Stream outputs follow the registered state, so they stay stable under stall.
  always_comb begin
    phases_in.ready = (state_q == COLLECT) && !reset;
    frame_out.valid = (state_q == EMIT);
    frame_out.data  = frame_out.valid ? rd_data : '0;
    frame_out.dest  = frame_out.valid ? DEST_WIDTH'(idx_q) : '0;
    frame_out.last  = frame_out.valid && is_last;
  end

  assign frame_error   = err_q;
  assign frames_done   = frames_done_q;
  assign dbg_state     = state_q;
  assign dbg_err_cause = cause_q;

endmodule
